// File: rtl/ucie_sb_pkg.sv
// Shared types and constants for the sideband TX arbiter.
package ucie_sb_pkg;

  localparam int unsigned SB_PKT_W           = 76;
  localparam int unsigned SB_DEFAULT_CREDITS = 4;

  // Packet payload as seen on the PHY channel (type field renamed: 'type' is reserved).
  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  length;
    logic [3:0]  pkt_type;
  } sb_pkt_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sb_arb_state_e;

endpackage

// File: rtl/ucie_sb_rr_picker.sv
// Rotate-priority encoder: first set request at or above rr_ptr, wrapping.
module ucie_sb_rr_picker #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant_oh_c,
  output logic [IDX_W-1:0]   grant_idx_c
);

  logic        found;
  int unsigned idx;

  // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
  always_comb begin
    grant_oh_c  = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found                    = 1'b1;
        grant_oh_c[IDX_W'(idx)]  = 1'b1;
        grant_idx_c              = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ucie_sb_tx_arbiter.sv
// Sideband TX arbiter: shares one PHY packet channel among NUM_REQ clients,
// gated by remote RX credits, with a stall timeout on the PHY handshake.
module ucie_sb_tx_arbiter
  import ucie_sb_pkg::*;
#(
  parameter  int unsigned NUM_REQ  = 4,
  parameter  int unsigned CREDITS  = SB_DEFAULT_CREDITS,
  parameter  int unsigned TIMEOUT  = 1024,
  parameter  bit          PRIO0_EN = 1'b1,
  localparam int unsigned IDX_W    = $clog2(NUM_REQ),
  localparam int unsigned CRD_W    = $clog2(CREDITS + 1)
) (
  input  logic                  aux_clk,
  input  logic                  aux_reset,
  input  logic                  sb_enable,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*64-1:0] req_data,
  input  logic [NUM_REQ*8-1:0]  req_length,
  input  logic [NUM_REQ*4-1:0]  req_type,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  tx_packet_valid,
  output logic [63:0]           tx_packet_data,
  output logic [7:0]            tx_packet_length,
  output logic [3:0]            tx_packet_type,
  input  logic                  tx_packet_ready,
  input  logic                  credit_return,
  output logic [IDX_W-1:0]      grant_id,
  output logic [CRD_W-1:0]      credits_avail,
  output logic                  timeout_err,
  output logic                  credit_ovf_err
);

  localparam int unsigned       TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [CRD_W-1:0]  CRD_MAX  = CRD_W'(CREDITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

  sb_arb_state_e     state_q, state_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  sb_pkt_t           pkt_q, pkt_d;
  logic [IDX_W-1:0]  grant_id_q, grant_id_d;
  logic              tmo_q, tmo_d;
  logic              ovf_q, ovf_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [SB_PKT_W-1:0] win_raw;
  sb_pkt_t            win_pkt;
  logic               grant_ok;
  logic               consume;
  logic [IDX_W-1:0]   next_ptr;

  ucie_sb_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant_oh_c  (pick_oh),
    .grant_idx_c (pick_idx)
  );

  // Requester 0 overrides the round-robin choice when priority is enabled.
  always_comb begin
    win_oh  = pick_oh;
    win_idx = pick_idx;
    if (PRIO0_EN && req_valid[0]) begin
      win_oh  = NUM_REQ'(1);
      win_idx = '0;
    end
  end

  // Mux the winning requester's payload.
  always_comb begin
    win_raw = {req_data[64*int'(win_idx) +: 64],
               req_length[8*int'(win_idx) +: 8],
               req_type[4*int'(win_idx) +: 4]};
    win_pkt = sb_pkt_t'(win_raw);
  end

  assign grant_ok = sb_enable && !aux_reset && (credits_q != '0) && (|req_valid);
  assign next_ptr = (grant_id_q == IDX_LAST) ? '0 : grant_id_q + IDX_W'(1);

  // Next-state, grant, credit and error logic.
  always_comb begin
    state_d    = state_q;
    credits_d  = credits_q;
    rr_ptr_d   = rr_ptr_q;
    timer_d    = timer_q;
    pkt_d      = pkt_q;
    grant_id_d = grant_id_q;
    tmo_d      = tmo_q;
    ovf_d      = ovf_q;
    req_ready  = '0;
    consume    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_ok) begin
          req_ready  = win_oh;
          pkt_d      = win_pkt;
          grant_id_d = win_idx;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_packet_ready) begin
          consume  = 1'b1;
          rr_ptr_d = next_ptr;
          timer_d  = '0;
          state_d  = IDLE;
        end else if (timer_q == TMR_LAST) begin
          // Stalled PHY: drop the packet without spending a credit.
          tmo_d    = 1'b1;
          rr_ptr_d = next_ptr;
          timer_d  = '0;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A return coinciding with a consume cancels out and cannot overflow.
    if (credit_return && !consume) begin
      if (credits_q == CRD_MAX) begin
        ovf_d = 1'b1;
      end else begin
        credits_d = credits_q + CRD_W'(1);
      end
    end else if (consume && !credit_return) begin
      credits_d = credits_q - CRD_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge aux_clk) begin
    if (aux_reset) begin
      state_q    <= IDLE;
      credits_q  <= CRD_MAX;
      rr_ptr_q   <= '0;
      timer_q    <= '0;
      pkt_q      <= '0;
      grant_id_q <= '0;
      tmo_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      rr_ptr_q   <= rr_ptr_d;
      timer_q    <= timer_d;
      pkt_q      <= pkt_d;
      grant_id_q <= grant_id_d;
      tmo_q      <= tmo_d;
      ovf_q      <= ovf_d;
    end
  end

  assign tx_packet_valid  = (state_q == SEND);
  assign tx_packet_data   = pkt_q.data;
  assign tx_packet_length = pkt_q.length;
  assign tx_packet_type   = pkt_q.pkt_type;
  assign grant_id         = grant_id_q;
  assign credits_avail    = credits_q;
  assign timeout_err      = tmo_q;
  assign credit_ovf_err   = ovf_q;

endmodule

// File: tb/tb_ucie_sb_tx_arbiter.sv
// Randomized scoreboard bench for ucie_sb_tx_arbiter (4 requesters, 4 credits, TIMEOUT 16).
`timescale 1ns/1ps
module tb_ucie_sb_tx_arbiter;
  import ucie_sb_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CREDITS = 4;
  localparam int unsigned TIMEOUT = 16;

  logic                  aux_clk = 1'b0;
  logic                  aux_reset;
  logic                  sb_enable;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*64-1:0] req_data;
  logic [NUM_REQ*8-1:0]  req_length;
  logic [NUM_REQ*4-1:0]  req_type;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  tx_packet_valid;
  logic [63:0]           tx_packet_data;
  logic [7:0]            tx_packet_length;
  logic [3:0]            tx_packet_type;
  logic                  tx_packet_ready;
  logic                  credit_return;
  logic [1:0]            grant_id;
  logic [2:0]            credits_avail;
  logic                  timeout_err;
  logic                  credit_ovf_err;

  ucie_sb_tx_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .CREDITS  (CREDITS),
    .TIMEOUT  (TIMEOUT),
    .PRIO0_EN (1'b1)
  ) dut (
    .aux_clk          (aux_clk),
    .aux_reset        (aux_reset),
    .sb_enable        (sb_enable),
    .req_valid        (req_valid),
    .req_data         (req_data),
    .req_length       (req_length),
    .req_type         (req_type),
    .req_ready        (req_ready),
    .tx_packet_valid  (tx_packet_valid),
    .tx_packet_data   (tx_packet_data),
    .tx_packet_length (tx_packet_length),
    .tx_packet_type   (tx_packet_type),
    .tx_packet_ready  (tx_packet_ready),
    .credit_return    (credit_return),
    .grant_id         (grant_id),
    .credits_avail    (credits_avail),
    .timeout_err      (timeout_err),
    .credit_ovf_err   (credit_ovf_err)
  );

  always #5 aux_clk = ~aux_clk;

  typedef struct packed {
    logic [1:0] id;
    sb_pkt_t    pkt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Requester-side stimulus state.
  logic [3:0]  rv;
  logic [63:0] rd[4];
  logic [7:0]  rl[4];
  logic [3:0]  rt[4];
  int          last_grant = -1;

  // Stimulus knobs.
  logic [3:0]  mask;
  int unsigned req_pct, drop_pct, rdy_pct, cret_pct, en_pct;
  bit          force_cret, cret_full_ok, rst_now;

  // Reference model state.
  bit m_busy, m_tmo, m_ovf;
  int m_id, m_timer, m_credits, m_rr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_tmo = 0; m_ovf = 0;
    m_id = 0; m_timer = 0; m_credits = CREDITS; m_rr = 0;
  endtask

  // Predict this cycle's accept pulse, compare, then advance the model one clock.
  task automatic model_eval();
    int         g;
    logic [3:0] exp_rdy;
    bit         consume;
    exp_t       e;
    g = -1;
    if (!rst_now && !m_busy && sb_enable && m_credits > 0) begin
      if (rv[0]) g = 0;
      else
        for (int k = 0; k < 4; k++)
          if (g < 0 && rv[2'((m_rr + k) % 4)]) g = (m_rr + k) % 4;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[2'(g)] = 1'b1;

    check("req_ready",      64'(req_ready),      64'(exp_rdy));
    check("tx_valid",       64'(tx_packet_valid), 64'(m_busy));
    check("credits_avail",  64'(credits_avail),  64'(m_credits));
    check("timeout_err",    64'(timeout_err),    64'(m_tmo));
    check("credit_ovf_err", 64'(credit_ovf_err), 64'(m_ovf));

    last_grant = g;
    if (rst_now) begin
      model_reset();
      last_grant = -1;
    end else begin
      consume = m_busy && tx_packet_ready;
      if (m_busy) begin
        if (tx_packet_ready || m_timer == int'(TIMEOUT) - 1) begin
          if (!tx_packet_ready) m_tmo = 1;
          m_busy  = 0;
          m_rr    = (m_id + 1) % 4;
          m_timer = 0;
        end else begin
          m_timer++;
        end
      end
      if (g >= 0) begin
        m_busy = 1;
        m_id   = g;
        e.id           = 2'(g);
        e.pkt.data     = rd[2'(g)];
        e.pkt.length   = rl[2'(g)];
        e.pkt.pkt_type = rt[2'(g)];
        exp_q.push_back(e);
      end
      if (credit_return && !consume) begin
        if (m_credits == int'(CREDITS)) m_ovf = 1;
        else m_credits++;
      end else if (consume && !credit_return) begin
        m_credits--;
      end
    end
  endtask

  // One clock of stimulus: update requesters, drive inputs, then check and model.
  task automatic step();
    @(negedge aux_clk);
    for (int i = 0; i < 4; i++) begin
      if (last_grant == i) rv[i] = 1'b0;
      if (!rv[i] && mask[i] && ($urandom_range(99) < req_pct)) begin
        rv[i] = 1'b1;
        rd[i] = {$urandom(), $urandom()};
        rl[i] = 8'($urandom());
        rt[i] = 4'($urandom());
      end else if (rv[i] && drop_pct != 0 && ($urandom_range(99) < drop_pct)) begin
        rv[i] = 1'b0;
      end
      req_data[64*i +: 64] = rd[i];
      req_length[8*i +: 8] = rl[i];
      req_type[4*i +: 4]   = rt[i];
    end
    req_valid       = rv;
    tx_packet_ready = ($urandom_range(99) < rdy_pct);
    sb_enable       = ($urandom_range(99) < en_pct);
    credit_return   = force_cret ||
                      (cret_pct != 0 && ($urandom_range(99) < cret_pct) &&
                       (cret_full_ok || m_credits < int'(CREDITS)));
    aux_reset       = rst_now;
    #1;
    model_eval();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Monitor: pops an expectation on each new packet and checks it stays stable.
  initial begin : monitor
    exp_t cur;
    bit   prev_v;
    prev_v = 0;
    cur    = '0;
    forever begin
      @(negedge aux_clk);
      if (tx_packet_valid === 1'b1 && !prev_v) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pkt: grant_id %0d with no pending grant at %0t", grant_id, $time);
        end else begin
          cur = exp_q.pop_front();
          check("pkt_grant_id", 64'(grant_id),         64'(cur.id));
          check("pkt_data",     tx_packet_data,        cur.pkt.data);
          check("pkt_length",   64'(tx_packet_length), 64'(cur.pkt.length));
          check("pkt_type",     64'(tx_packet_type),   64'(cur.pkt.pkt_type));
        end
      end else if (tx_packet_valid === 1'b1) begin
        check("hold_grant_id", 64'(grant_id),       64'(cur.id));
        check("hold_data",     tx_packet_data,      cur.pkt.data);
        check("hold_length",   64'(tx_packet_length), 64'(cur.pkt.length));
      end
      prev_v = (tx_packet_valid === 1'b1);
    end
  end

  initial begin : driver
    int guard;
    rv = '0;
    for (int i = 0; i < 4; i++) begin rd[i] = '0; rl[i] = '0; rt[i] = '0; end
    mask = '0; req_pct = 0; drop_pct = 0; rdy_pct = 100; cret_pct = 0; en_pct = 100;
    force_cret = 0; cret_full_ok = 0; rst_now = 1;
    aux_reset = 1'b1; sb_enable = 1'b0; req_valid = '0; req_data = '0;
    req_length = '0; req_type = '0; tx_packet_ready = 1'b0; credit_return = 1'b0;
    model_reset();
    repeat (3) @(posedge aux_clk);
    @(negedge aux_clk);
    check("rst_grant_id", 64'(grant_id),         64'd0);
    check("rst_data",     tx_packet_data,        64'd0);
    check("rst_length",   64'(tx_packet_length), 64'd0);
    check("rst_type",     64'(tx_packet_type),   64'd0);
    check("rst_req_ready", 64'(req_ready),       64'd0);
    rst_now = 0;

    // Single request from requester 2.
    mask = 4'b0100; req_pct = 100; run(1);
    mask = 4'b0000; run(5);

    // Round robin among 1..3, credits replenished.
    mask = 4'b1110; cret_pct = 60; run(40);

    // Requester 0 override.
    mask = 4'b1011; run(30);

    // Credit exhaustion, single return, then overlapping consume/return.
    mask = 4'b1111; cret_pct = 0; run(20);
    force_cret = 1; run(1); force_cret = 0; run(4);
    cret_pct = 100; run(12);

    // Stalled PHY -> timeout, then recovery.
    cret_pct = 0; rdy_pct = 0; run(40);
    rdy_pct = 100; run(6);

    // Refill credits, then return one more for overflow.
    mask = 4'b0000; cret_pct = 100;
    guard = 0;
    while ((m_busy || m_credits < int'(CREDITS) || rv != 0) && guard < 60) begin
      step(); guard++;
    end
    if (guard >= 60) begin
      vectors++; miscompares++;
      $display("FAIL refill_wait: credits %0d busy %0d after %0d cycles", m_credits, m_busy, guard);
    end
    cret_pct = 0; force_cret = 1; cret_full_ok = 1; run(1);
    force_cret = 0; cret_full_ok = 0; run(2);

    // Reset in the middle of a SEND.
    mask = 4'b1111; req_pct = 100; rdy_pct = 0;
    guard = 0;
    while (!m_busy && guard < 50) begin step(); guard++; end
    if (!m_busy) begin
      vectors++; miscompares++;
      $display("FAIL reset_wait: no grant within %0d cycles", guard);
    end
    run(2);
    rst_now = 1; run(1); rst_now = 0;
    rdy_pct = 100; run(3);

    // Random mix.
    mask = 4'b1111; req_pct = 30; drop_pct = 3; rdy_pct = 70; cret_pct = 25; en_pct = 85;
    run(400);
    cret_full_ok = 1; cret_pct = 5; run(100); cret_full_ok = 0;

    // Drain outstanding traffic.
    mask = 4'b0000; drop_pct = 0; rdy_pct = 100; cret_pct = 50; en_pct = 100;
    run(60);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
